// File: rtl/pc_unit_if.sv
// Bus-side signal bundle for the program counter: select/increment controls,
// the internal ADL/ADH buses, and the PC and phase outputs.
interface pc_unit_if;
  logic       ADL_PCL;
  logic       PCL_PCL;
  logic       ADH_PCH;
  logic       PCH_PCH;
  logic       n_1PC;
  logic [7:0] ADL;
  logic [7:0] ADH;
  logic       PHI1;
  logic       PHI2;
  logic [7:0] PCL;
  logic [7:0] PCH;
  logic [7:0] PCL_ADL_v;
  logic [7:0] PCH_ADH_v;
  logic       PCLC;

  // Controller side: drives controls and buses, observes PC and phases.
  modport master (
    output ADL_PCL, PCL_PCL, ADH_PCH, PCH_PCH, n_1PC, ADL, ADH,
    input  PHI1, PHI2, PCL, PCH, PCL_ADL_v, PCH_ADH_v, PCLC
  );

  // Program counter side.
  modport slave (
    input  ADL_PCL, PCL_PCL, ADH_PCH, PCH_PCH, n_1PC, ADL, ADH,
    output PHI1, PHI2, PCL, PCH, PCL_ADL_v, PCH_ADH_v, PCLC
  );
endinterface

// File: rtl/pc_unit.sv
// 6502 program counter with two-stage select/increment. A single master clock
// is divided by an internal phase bit into PHI1/PHI2; the edge ending PHI1
// loads the PCLS/PCHS select latches, the edge ending PHI2 writes PC = PCS + inc.
module pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic      CLK,
  input  logic      n_RES,
  pc_unit_if.slave  bus
);

  logic        ph_q, ph_d;
  logic [7:0]  pcls_q, pcls_d;
  logic [7:0]  pchs_q, pchs_d;
  logic [7:0]  pcl_q, pcl_d;
  logic [7:0]  pch_q, pch_d;
  logic        pclc_q, pclc_d;
  logic        inc;
  logic [15:0] pc_sum;

  assign inc    = ~bus.n_1PC;
  // Full 16-bit add so FFFF+1 wraps to 0000 and PCL carry ripples into PCH.
  assign pc_sum = {pchs_q, pcls_q} + {15'd0, inc};

  // Next-state: select stage while ph=0, increment stage while ph=1.
  always_comb begin
    ph_d   = ~ph_q;
    pcls_d = pcls_q;
    pchs_d = pchs_q;
    pcl_d  = pcl_q;
    pch_d  = pch_q;
    pclc_d = pclc_q;
    if (!ph_q) begin
      // ADL/ADH load has priority over recirculation; neither means hold.
      if (bus.ADL_PCL)      pcls_d = bus.ADL;
      else if (bus.PCL_PCL) pcls_d = pcl_q;
      if (bus.ADH_PCH)      pchs_d = bus.ADH;
      else if (bus.PCH_PCH) pchs_d = pch_q;
    end else begin
      pcl_d  = pc_sum[7:0];
      pch_d  = pc_sum[15:8];
      pclc_d = inc & (pcls_q == 8'hFF);
    end
  end

  // State registers; reset discards any pending select or increment.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      ph_q   <= 1'b0;
      pcls_q <= RESET_PC[7:0];
      pchs_q <= RESET_PC[15:8];
      pcl_q  <= RESET_PC[7:0];
      pch_q  <= RESET_PC[15:8];
      pclc_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      pcls_q <= pcls_d;
      pchs_q <= pchs_d;
      pcl_q  <= pcl_d;
      pch_q  <= pch_d;
      pclc_q <= pclc_d;
    end
  end

  assign bus.PHI1      = ~ph_q;
  assign bus.PHI2      = ph_q;
  assign bus.PCL       = pcl_q;
  assign bus.PCH       = pch_q;
  assign bus.PCL_ADL_v = pcl_q;
  assign bus.PCH_ADH_v = pch_q;
  assign bus.PCLC      = pclc_q;

endmodule
